// File: rtl/fast_control_rx.sv
// ---------------------------------------------------------------------------
// fast_control_rx
//
// Receives one Hamming(8,4)-protected fast-control word per bunch crossing,
// corrects single-bit errors per nibble, decodes the command bits, keeps a
// local bunch-crossing counter and tracks BCR alignment with a small lock FSM.
//
// Pipeline: input register -> decode/output register (2 clk_bx latency).
//
// Ports
//   clk_bx          : bunch-crossing clock
//   reset           : synchronous, active-high reset
//   fc_stream_enc   : encoded word, [7:0] -> data[3:0], [15:8] -> data[7:4]
//   orb_length      : orbit length in bx (0 means 4096)
//   cnt_clear       : synchronous clear of the statistics counters
//   bcr, l1a, link_reset, buffer_clear, calib_pulse : data bits 0,1,2,3,5
//   dbg_bits        : {data[7], data[6], data[4]}
//   bx_id           : local bx counter, aligned with the command outputs
//   locked          : BCR alignment established
//   sec_err/ded_err : corrected / uncorrectable error pulses
//   l1a_count       : wrapping L1A counter
//   sec_count, ded_count, bcr_err_count : saturating error counters
//
// Build option: define FC_RX_ERR_COUNTERS_EN to implement sec_count,
// ded_count and bcr_err_count; otherwise they are tied to zero.
// ---------------------------------------------------------------------------
module fast_control_rx #(
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned MISS_LIMIT = 2
) (
    input  logic        clk_bx,
    input  logic        reset,
    input  logic [15:0] fc_stream_enc,
    input  logic [11:0] orb_length,
    input  logic        cnt_clear,
    output logic        bcr,
    output logic        l1a,
    output logic        link_reset,
    output logic        buffer_clear,
    output logic        calib_pulse,
    output logic [2:0]  dbg_bits,
    output logic [11:0] bx_id,
    output logic        locked,
    output logic        sec_err,
    output logic        ded_err,
    output logic [31:0] l1a_count,
    output logic [15:0] sec_count,
    output logic [15:0] ded_count,
    output logic [15:0] bcr_err_count
);

    localparam int unsigned GW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam int unsigned MW = (MISS_LIMIT < 2) ? 1 : $clog2(MISS_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_CHECK    = 2'd1,
        ST_LOCKED   = 2'd2
    } fsm_state_t;

    // Returns {single_err, double_err, d3, d2, d1, d0} for one code byte
    // laid out as {p0, d3, d2, d1, p3, d0, p2, p1}.
    function automatic logic [5:0] ham_dec(input logic [7:0] cw);
        logic [2:0] syn;
        logic       par_bad;
        logic [3:0] d;
        syn[0]  = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
        syn[1]  = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
        syn[2]  = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
        par_bad = ^cw;
        // Only data positions (3,5,6,7) need flipping; parity-bit hits leave data intact.
        d[0] = cw[2] ^ (par_bad && (syn == 3'd3));
        d[1] = cw[4] ^ (par_bad && (syn == 3'd5));
        d[2] = cw[5] ^ (par_bad && (syn == 3'd6));
        d[3] = cw[6] ^ (par_bad && (syn == 3'd7));
        if (!par_bad && (syn != 3'd0)) begin
            ham_dec = {1'b0, 1'b1, 4'd0};
        end else begin
            ham_dec = {par_bad, 1'b0, d};
        end
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            sat_inc = v;
        end else begin
            sat_inc = v + 16'd1;
        end
    endfunction

    logic [15:0]   enc_r;
    logic [5:0]    lo_s;
    logic [5:0]    hi_s;
    logic [7:0]    data_s;
    logic          single_s;
    logic          double_s;
    logic [11:0]   bx_inc_s;
    logic          expected_s;
    logic [11:0]   bx_nxt_s;
    fsm_state_t    state_r;
    fsm_state_t    state_nxt_s;
    logic [GW-1:0] good_r;
    logic [GW-1:0] good_nxt_s;
    logic [GW-1:0] good_inc_s;
    logic [MW-1:0] miss_r;
    logic [MW-1:0] miss_nxt_s;
    logic [MW-1:0] miss_inc_s;

    // Input capture stage.
    always_ff @(posedge clk_bx) begin
        if (reset) begin
            enc_r <= 16'd0;
        end else begin
            enc_r <= fc_stream_enc;
        end
    end

    // Decode both nibbles and compute the next bx counter value.
    always_comb begin
        lo_s       = ham_dec(enc_r[7:0]);
        hi_s       = ham_dec(enc_r[15:8]);
        data_s     = {hi_s[3:0], lo_s[3:0]};
        single_s   = lo_s[5] | hi_s[5];
        double_s   = lo_s[4] | hi_s[4];
        bx_inc_s   = bx_id + 12'd1;
        // 12-bit wrap makes orb_length == 0 behave as a 4096-bx orbit.
        expected_s = (bx_inc_s == orb_length);
        if (data_s[0] || expected_s) begin
            bx_nxt_s = 12'd0;
        end else begin
            bx_nxt_s = bx_inc_s;
        end
    end

    // Lock FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        good_nxt_s  = good_r;
        miss_nxt_s  = miss_r;
        good_inc_s  = good_r + GW'(1);
        miss_inc_s  = miss_r + MW'(1);
        case (state_r)
            ST_UNLOCKED: begin
                if (data_s[0]) begin
                    state_nxt_s = ST_CHECK;
                    good_nxt_s  = GW'(1);
                end else begin
                    state_nxt_s = ST_UNLOCKED;
                end
            end
            ST_CHECK: begin
                if (data_s[0] && expected_s) begin
                    good_nxt_s = good_inc_s;
                    if (good_inc_s == GW'(LOCK_COUNT)) begin
                        state_nxt_s = ST_LOCKED;
                        miss_nxt_s  = '0;
                    end else begin
                        state_nxt_s = ST_CHECK;
                    end
                end else if (data_s[0]) begin
                    good_nxt_s = GW'(1);
                end else if (expected_s) begin
                    state_nxt_s = ST_UNLOCKED;
                end else begin
                    state_nxt_s = ST_CHECK;
                end
            end
            ST_LOCKED: begin
                if (data_s[0] && expected_s) begin
                    miss_nxt_s = '0;
                end else if (data_s[0]) begin
                    state_nxt_s = ST_CHECK;
                    good_nxt_s  = GW'(1);
                end else if (expected_s) begin
                    // A double-error word has bcr forced to 0, so it lands here as a miss.
                    miss_nxt_s = miss_inc_s;
                    if (miss_inc_s == MW'(MISS_LIMIT)) begin
                        state_nxt_s = ST_UNLOCKED;
                    end else begin
                        state_nxt_s = ST_LOCKED;
                    end
                end else begin
                    state_nxt_s = ST_LOCKED;
                end
            end
            default: begin
                state_nxt_s = ST_UNLOCKED;
                good_nxt_s  = '0;
                miss_nxt_s  = '0;
            end
        endcase
    end

    // Lock FSM state and counters.
    always_ff @(posedge clk_bx) begin
        if (reset) begin
            state_r <= ST_UNLOCKED;
            good_r  <= '0;
            miss_r  <= '0;
        end else begin
            state_r <= state_nxt_s;
            good_r  <= good_nxt_s;
            miss_r  <= miss_nxt_s;
        end
    end

    // Registered command, debug, error and bx outputs.
    always_ff @(posedge clk_bx) begin
        if (reset) begin
            bcr          <= 1'b0;
            l1a          <= 1'b0;
            link_reset   <= 1'b0;
            buffer_clear <= 1'b0;
            calib_pulse  <= 1'b0;
            dbg_bits     <= 3'd0;
            sec_err      <= 1'b0;
            ded_err      <= 1'b0;
            bx_id        <= 12'd0;
            locked       <= 1'b0;
        end else begin
            bcr          <= data_s[0];
            l1a          <= data_s[1];
            link_reset   <= data_s[2];
            buffer_clear <= data_s[3];
            calib_pulse  <= data_s[5];
            dbg_bits     <= {data_s[7], data_s[6], data_s[4]};
            sec_err      <= single_s;
            ded_err      <= double_s;
            bx_id        <= bx_nxt_s;
            locked       <= (state_nxt_s == ST_LOCKED);
        end
    end

    // Wrapping L1A counter; clear wins over a coincident increment.
    always_ff @(posedge clk_bx) begin
        if (reset || cnt_clear) begin
            l1a_count <= 32'd0;
        end else if (data_s[1]) begin
            l1a_count <= l1a_count + 32'd1;
        end else begin
            l1a_count <= l1a_count;
        end
    end

`ifdef FC_RX_ERR_COUNTERS_EN
    logic bcr_err_ev_s;
    assign bcr_err_ev_s = (state_r == ST_LOCKED) && data_s[0] && !expected_s;

    // Saturating error counters; clear wins over a coincident increment.
    always_ff @(posedge clk_bx) begin
        if (reset || cnt_clear) begin
            sec_count     <= 16'd0;
            ded_count     <= 16'd0;
            bcr_err_count <= 16'd0;
        end else begin
            sec_count     <= single_s     ? sat_inc(sec_count)     : sec_count;
            ded_count     <= double_s     ? sat_inc(ded_count)     : ded_count;
            bcr_err_count <= bcr_err_ev_s ? sat_inc(bcr_err_count) : bcr_err_count;
        end
    end
`else
    assign sec_count     = 16'd0;
    assign ded_count     = 16'd0;
    assign bcr_err_count = 16'd0;
`endif

endmodule

// File: tb/tb_fast_control_rx.sv
// ---------------------------------------------------------------------------
// tb_fast_control_rx
//
// Directed, table-driven bench for fast_control_rx. A vector table covers
// single-word decoding and error handling; hand-written orbit sequences
// cover lock acquisition, misplaced/missing BCRs, counter clear and reset.
// ---------------------------------------------------------------------------
module tb_fast_control_rx;

`ifdef FC_RX_ERR_COUNTERS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk_bx;
    logic        reset;
    logic [15:0] fc_stream_enc;
    logic [11:0] orb_length;
    logic        cnt_clear;
    logic        bcr;
    logic        l1a;
    logic        link_reset;
    logic        buffer_clear;
    logic        calib_pulse;
    logic [2:0]  dbg_bits;
    logic [11:0] bx_id;
    logic        locked;
    logic        sec_err;
    logic        ded_err;
    logic [31:0] l1a_count;
    logic [15:0] sec_count;
    logic [15:0] ded_count;
    logic [15:0] bcr_err_count;

    int n_checks;
    int n_fail;

    fast_control_rx #(
        .LOCK_COUNT(4),
        .MISS_LIMIT(2)
    ) dut (
        .clk_bx        (clk_bx),
        .reset         (reset),
        .fc_stream_enc (fc_stream_enc),
        .orb_length    (orb_length),
        .cnt_clear     (cnt_clear),
        .bcr           (bcr),
        .l1a           (l1a),
        .link_reset    (link_reset),
        .buffer_clear  (buffer_clear),
        .calib_pulse   (calib_pulse),
        .dbg_bits      (dbg_bits),
        .bx_id         (bx_id),
        .locked        (locked),
        .sec_err       (sec_err),
        .ded_err       (ded_err),
        .l1a_count     (l1a_count),
        .sec_count     (sec_count),
        .ded_count     (ded_count),
        .bcr_err_count (bcr_err_count)
    );

    initial clk_bx = 1'b0;
    always #5 clk_bx = ~clk_bx;

    typedef struct {
        logic [15:0] enc;
        logic [9:0]  exp;   // {bcr,l1a,link_reset,buffer_clear,calib_pulse,dbg[2:0],sec,ded}
        string       name;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one word at the falling edge, then advance one bx.
    task automatic step(input logic [15:0] w);
        fc_stream_enc = w;
        @(negedge clk_bx);
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        fc_stream_enc = 16'h0000;
        @(negedge clk_bx);
        chk("reset_outputs",
            {40'd0, bcr, l1a, link_reset, buffer_clear, calib_pulse, dbg_bits,
             bx_id, locked, sec_err, ded_err}, 64'd0);
        chk("reset_l1a_count", {32'd0, l1a_count}, 64'd0);
        chk("reset_err_counts", {16'd0, sec_count, ded_count, bcr_err_count}, 64'd0);
        reset = 1'b0;
    endtask

    // One 45-bx orbit: optional BCR in word 0, fill in words 1..44.
    task automatic orbit(input bit with_bcr, input bit exp_lock,
                         input logic [11:0] exp_prev_bx, input logic [15:0] fill);
        step(with_bcr ? 16'h0087 : 16'h0000);
        chk("bx_before_orbit", {52'd0, bx_id}, {52'd0, exp_prev_bx});
        step(fill);
        chk("orbit_bcr", {63'd0, bcr}, {63'd0, with_bcr});
        chk("orbit_bx0", {52'd0, bx_id}, 64'd0);
        chk("orbit_locked", {63'd0, locked}, {63'd0, exp_lock});
        for (int i = 0; i < 43; i++) begin
            step(fill);
        end
        chk("orbit_bx43", {52'd0, bx_id}, 64'd43);
        chk("orbit_locked_end", {63'd0, locked}, {63'd0, exp_lock});
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b1;
        fc_stream_enc = 16'h0000;
        orb_length    = 12'd45;
        cnt_clear     = 1'b0;

        vecs[0]  = '{16'h0000, 10'b00000_000_00, "idle"};
        vecs[1]  = '{16'h0087, 10'b10000_000_00, "bcr"};
        vecs[2]  = '{16'h0099, 10'b01000_000_00, "l1a"};
        vecs[3]  = '{16'h00AA, 10'b00100_000_00, "link_reset"};
        vecs[4]  = '{16'h004B, 10'b00010_000_00, "buffer_clear"};
        vecs[5]  = '{16'h9900, 10'b00001_000_00, "calib"};
        vecs[6]  = '{16'h8700, 10'b00000_001_00, "dbg_bit4"};
        vecs[7]  = '{16'hAA00, 10'b00000_010_00, "dbg_bit6"};
        vecs[8]  = '{16'h4B00, 10'b00000_100_00, "dbg_bit7"};
        vecs[9]  = '{16'h0098, 10'b01000_000_10, "l1a_p1_flip"};
        vecs[10] = '{16'h009A, 10'b00000_000_01, "l1a_double"};
        vecs[11] = '{16'h001E, 10'b11000_000_00, "bcr_and_l1a"};
        vecs[12] = '{16'h0019, 10'b01000_000_10, "l1a_p0_flip"};
        vecs[13] = '{16'h9A98, 10'b01000_000_11, "sec_lo_ded_hi"};
        vecs[14] = '{16'hFF87, 10'b10001_111_00, "all_hi_bcr"};
        vecs[15] = '{16'h0089, 10'b01000_000_10, "l1a_d1_flip"};

        // Single-word decode table
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(vecs[i].enc);
            step(16'h0000);
            chk(vecs[i].name,
                {54'd0, bcr, l1a, link_reset, buffer_clear, calib_pulse, dbg_bits, sec_err, ded_err},
                {54'd0, vecs[i].exp});
        end
        chk("table_l1a_count", {32'd0, l1a_count}, 64'd6);
        chk("table_sec_count", {48'd0, sec_count}, ERR_EN ? 64'd4 : 64'd0);
        chk("table_ded_count", {48'd0, ded_count}, ERR_EN ? 64'd2 : 64'd0);
        chk("table_bcr_err_count", {48'd0, bcr_err_count}, 64'd0);

        // cnt_clear coincident with an l1a increment
        step(16'h0099);
        cnt_clear = 1'b1;
        step(16'h0000);
        chk("clr_l1a_pulse", {63'd0, l1a}, 64'd1);
        chk("clr_l1a_count", {32'd0, l1a_count}, 64'd0);
        chk("clr_err_counts", {16'd0, sec_count, ded_count, bcr_err_count}, 64'd0);
        cnt_clear = 1'b0;
        step(16'h0000);
        chk("clr_l1a_count_hold", {32'd0, l1a_count}, 64'd0);

        // Lock acquisition: locked rises with the 4th BCR
        do_reset();
        orbit(1'b1, 1'b0, 12'd1,  16'h0000);
        orbit(1'b1, 1'b0, 12'd44, 16'h0000);
        orbit(1'b1, 1'b0, 12'd44, 16'h0000);
        orbit(1'b1, 1'b1, 12'd44, 16'h0000);
        orbit(1'b1, 1'b1, 12'd44, 16'h0000);

        // Misplaced BCR at bx 20 while locked, then relock after 3 more
        step(16'h0087);
        for (int i = 0; i < 19; i++) begin
            step(16'h0000);
        end
        orbit(1'b1, 1'b0, 12'd19, 16'h0000);
        chk("bcr_err_count", {48'd0, bcr_err_count}, ERR_EN ? 64'd1 : 64'd0);
        orbit(1'b1, 1'b0, 12'd44, 16'h0000);
        orbit(1'b1, 1'b0, 12'd44, 16'h0000);
        orbit(1'b1, 1'b1, 12'd44, 16'h0000);

        // L1A on every non-BCR word of one orbit
        orbit(1'b1, 1'b1, 12'd44, 16'h0099);
        orbit(1'b1, 1'b1, 12'd44, 16'h0000);
        chk("orbit_l1a_count", {32'd0, l1a_count}, 64'd44);

        // Reset while locked with counters nonzero
        step(16'h0099);
        do_reset();

        // Relock, then drop two BCRs in a row
        orbit(1'b1, 1'b0, 12'd1,  16'h0000);
        orbit(1'b1, 1'b0, 12'd44, 16'h0000);
        orbit(1'b1, 1'b0, 12'd44, 16'h0000);
        orbit(1'b1, 1'b1, 12'd44, 16'h0000);
        orbit(1'b0, 1'b1, 12'd44, 16'h0000);
        orbit(1'b0, 1'b0, 12'd44, 16'h0000);
        orbit(1'b0, 1'b0, 12'd44, 16'h0000);
        chk("post_reset_l1a_count", {32'd0, l1a_count}, 64'd0);
        chk("post_reset_bcr_err", {48'd0, bcr_err_count}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fast_control_rx.md
FAST_CONTROL_RX -- requirements
Module: fast_control_rx

Interface
REQ-001 SHALL have parameter LOCK_COUNT, default 4: number of consecutive correctly placed BCRs needed to declare lock.
REQ-002 SHALL have parameter MISS_LIMIT, default 2: number of consecutive missing BCRs, while locked, that drops lock.
REQ-003 SHALL have port clk_bx, input, 1 bit: bunch-crossing clock, the only clock in the block.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port fc_stream_enc, input, 16 bits: one encoded fast-control word per clk_bx; [7:0] carries data bits 3:0, [15:8] carries data bits 7:4.
REQ-006 SHALL have port orb_length, input, 12 bits: orbit length in bx; the value is quasi-static.
REQ-007 SHALL have port cnt_clear, input, 1 bit: synchronous clear of all counters.
REQ-008 SHALL have decoded command outputs bcr, l1a, link_reset, buffer_clear and calib_pulse, each output, 1 bit: data bits 0, 1, 2, 3 and 5 respectively.
REQ-009 SHALL have port dbg_bits, output, 3 bits: {data bit 7, data bit 6, data bit 4}.
REQ-010 SHALL have port bx_id, output, 12 bits: local bx counter, aligned with the command outputs.
REQ-011 SHALL have port locked, output, 1 bit: high in state LOCKED.
REQ-012 SHALL have ports sec_err and ded_err, output, 1 bit each: one-cycle pulses for a corrected error and an uncorrectable error.
REQ-013 SHALL have ports l1a_count (32 bits), sec_count, ded_count and bcr_err_count (16 bits each), all outputs.

Function
REQ-014 Each byte SHALL be decoded as Hamming(8,4) with layout [7:0] = {p0, d3, d2, d1, p3, d0, p2, p1}, where:
- p1 = d0^d1^d3
- p2 = d0^d2^d3
- p3 = d1^d2^d3
- p0 = XOR of bits [6:0]
REQ-015 Syndrome handling SHALL be:
- syndrome 0, parity good: clean.
- syndrome nonzero, parity bad: correct the indicated bit and count it as a single error.
- syndrome 0, parity bad: p0 error; data is valid and it counts as a single error.
- syndrome nonzero, parity good: double error; that nibble's data SHALL be forced to 0.
REQ-016 sec_err SHALL pulse if either nibble has a single error; ded_err SHALL pulse if either nibble has a double error; both may pulse in the same cycle.
REQ-017 Latency SHALL be exactly 2 clk_bx from input sampling to the command, dbg_bits and error outputs: one input register stage, then one decode/output register stage.
REQ-018 bx_id SHALL update in the same cycle as the outputs.
- When bcr is output, bx_id SHALL be 0.
- Otherwise bx_id SHALL be 0 if (previous bx_id + 1) mod 4096 == orb_length, else previous bx_id + 1.
- orb_length = 0 therefore gives a 4096-bx orbit.
REQ-019 A BCR is "expected" when (previous bx_id + 1) mod 4096 == orb_length.
REQ-020 The FSM SHALL have states UNLOCKED, CHECK and LOCKED, with a good-BCR counter and a miss counter. Transitions:
- UNLOCKED: the first BCR goes to CHECK; good counter = 1.
- CHECK, expected BCR: increment the good counter; on reaching LOCK_COUNT go to LOCKED and clear the miss counter.
- CHECK, misplaced BCR: set good counter = 1 and stay in CHECK.
- CHECK, expected but absent BCR: go to UNLOCKED.
- LOCKED, expected BCR: clear the miss counter.
- LOCKED, expected but absent BCR: increment the miss counter; on reaching MISS_LIMIT go to UNLOCKED. A double-error word counts as absent.
- LOCKED, misplaced BCR: increment bcr_err_count, set good counter = 1 and go to CHECK.
REQ-021 Commands SHALL be output regardless of lock state; BCR and L1A in the same word SHALL both be output.
REQ-022 l1a_count SHALL increment on every output l1a and wrap at 2^32.
REQ-023 sec_count, ded_count and bcr_err_count SHALL saturate at 16'hFFFF.
REQ-024 cnt_clear SHALL zero all counters. If it coincides with an increment event, the counter SHALL be 0 in the next cycle.

Reset
REQ-025 While reset is high, at each clk_bx:
- all outputs SHALL be driven to 0;
- the FSM SHALL go to UNLOCKED;
- the pipeline registers and internal counters SHALL be cleared.
REQ-026 Reset SHALL take effect mid-orbit or mid-lock without spurious pulses; decoding SHALL resume on the first cycle after reset deasserts.

Configuration
REQ-027 With macro FC_RX_ERR_COUNTERS_EN defined, sec_count, ded_count and bcr_err_count SHALL be implemented as specified.
REQ-028 Without FC_RX_ERR_COUNTERS_EN:
- sec_count, ded_count and bcr_err_count SHALL be tied to 0 and their registers omitted;
- sec_err, ded_err, l1a_count and the FSM SHALL be unaffected.

Verification
REQ-029 orb_length=45, low byte 8'h87 every 45 cycles, otherwise 16'h0000 -> locked rises at the 4th BCR; bx_id counts 0..44; bcr aligns with bx_id=0.
REQ-030 Input 16'h0099 -> l1a pulses 2 cycles later and l1a_count=1; input 16'h0098 -> l1a pulse, sec_err pulse, sec_count=1.
REQ-031 Input 16'h009A (double flip) -> no l1a, ded_err pulse, ded_count=1, l1a_count unchanged.
REQ-032 Locked, BCR injected at bx_id=20 -> bcr_err_count=1; locked falls; bx_id=0 on that cycle; relock after 3 more expected BCRs.
REQ-033 Locked, BCR omitted for 2 consecutive orbits -> locked falls at the 2nd expected position; bx_id keeps wrapping at 44.
REQ-034 reset pulsed while locked with counters nonzero -> next cycle all outputs 0 and FSM in UNLOCKED; cnt_clear coincident with an l1a -> l1a_count=0.
